// File: rtl/data_mem_access_unit_pkg.sv
// Shared core definitions for the MEM-stage data access unit:
// access widths, bus size codes and FSM state type.
package data_mem_access_unit_pkg;

    localparam logic [1:0] MEM_WIDTH1 = 2'd1;
    localparam logic [1:0] MEM_WIDTH2 = 2'd2;
    localparam logic [1:0] MEM_WIDTH4 = 2'd3;

    localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
    localparam logic [1:0] BUS_SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        DM_IDLE,
        DM_REQ,
        DM_WAIT,
        DM_CANCEL,
        DM_DONE
    } dm_acc_state_t;

    // Unused width code falls back to a full word
    function automatic logic [1:0] bus_size(input logic [1:0] w);
        logic [1:0] s;
        s = BUS_SIZE_WORD;
        unique case (1'b1)
            (w == MEM_WIDTH1): s = BUS_SIZE_BYTE;
            (w == MEM_WIDTH2): s = BUS_SIZE_HALF;
            default:           s = BUS_SIZE_WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/data_mem_access_unit.sv
// MEM-stage data access unit: one outstanding SRAM-like bus access,
// with flush cancellation and a held response until the pipe advances.
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    input  logic [1:0]        mem_size,
    input  logic              flush,
    input  logic              pipe_advance,
    output logic              mem_stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    dm_acc_state_t     r_state;
    dm_acc_state_t     w_next;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_size;
    logic [31:0]       r_rdata;
    logic              w_capture;
    logic              w_load_resp;

    assign w_capture   = (r_state == DM_IDLE) && mem_valid && !flush;
    assign w_load_resp = (r_state == DM_WAIT) && data_data_ok && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            DM_IDLE: begin
                if (mem_valid && !flush) w_next = DM_REQ;
            end
            DM_REQ: begin
                if (data_addr_ok) w_next = flush ? DM_CANCEL : DM_WAIT;
                else if (flush)   w_next = DM_IDLE;
            end
            DM_WAIT: begin
                if (data_data_ok) w_next = flush ? DM_IDLE : DM_DONE;
                else if (flush)   w_next = DM_CANCEL;
            end
            // Drain the orphaned response before accepting new work
            DM_CANCEL: begin
                if (data_data_ok) w_next = DM_IDLE;
            end
            DM_DONE: begin
                if (pipe_advance || flush) w_next = DM_IDLE;
            end
            default: w_next = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_size  <= '0;
        end else if (w_capture) begin
            r_wr    <= mem_write;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_size  <= bus_size(mem_size);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_load_resp) begin
            r_rdata <= r_wr ? 32'h0 : data_rdata;
        end
    end

    assign data_req   = (r_state == DM_REQ);
    assign data_wr    = r_wr;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;
    assign data_wstrb = r_wstrb;
    assign data_size  = r_size;

    assign resp_valid = (r_state == DM_DONE);
    assign resp_rdata = r_rdata;

    // Gated by resetn so the stall drops the instant reset asserts
    assign mem_stall = resetn && (w_capture
                                  || (r_state == DM_REQ)
                                  || (r_state == DM_WAIT)
                                  || (r_state == DM_CANCEL));

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit: load/store paths,
// flush cancellation, held response and mid-access reset.
module tb_data_mem_access_unit;
    import data_mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_write, flush, pipe_advance;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  mem_size;
    logic        mem_stall, resp_valid, data_req, data_wr;
    logic [31:0] resp_rdata, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_size(mem_size),
        .flush(flush), .pipe_advance(pipe_advance),
        .mem_stall(mem_stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid    = 1'b0; mem_write = 1'b0; flush = 1'b0;
        pipe_advance = 1'b0; mem_addr  = '0;   mem_wdata = '0;
        mem_wstrb    = '0;   mem_size  = MEM_WIDTH4;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [1:0] sz);
        mem_valid = 1'b1; mem_write = 1'b0; mem_addr = a;
        mem_size  = sz;   mem_wstrb = 4'b0000; mem_wdata = '0;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        mem_valid = 1'b1;
        tick(); tick(); settle();
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_req", {31'b0, data_req}, 32'd0);
        chk("rst_rv", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        tick();
        resetn = 1'b1; mem_valid = 1'b0;
        data_data_ok = 1'b1; data_addr_ok = 1'b1;
        tick();
        data_data_ok = 1'b0; data_addr_ok = 1'b0;
        settle();
        chk("stray_ok_idle", {31'b0, data_req}, 32'd0);

        // Word load, minimum latency
        tick();
        issue_load(32'h1000, MEM_WIDTH4);
        settle();
        chk("ld_N_stall", {31'b0, mem_stall}, 32'd1);
        chk("ld_N_req", {31'b0, data_req}, 32'd0);
        tick();
        mem_addr = 32'hFFFF_0000; data_addr_ok = 1'b1;
        settle();
        chk("ld_N1_req", {31'b0, data_req}, 32'd1);
        chk("ld_N1_addr", data_addr, 32'h1000);
        chk("ld_N1_wr", {31'b0, data_wr}, 32'd0);
        chk("ld_N1_size", {30'b0, data_size}, 32'd2);
        chk("ld_N1_stall", {31'b0, mem_stall}, 32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        settle();
        chk("ld_N2_req", {31'b0, data_req}, 32'd0);
        chk("ld_N2_stall", {31'b0, mem_stall}, 32'd1);
        chk("ld_N2_rv", {31'b0, resp_valid}, 32'd0);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        chk("ld_N3_rv", {31'b0, resp_valid}, 32'd1);
        chk("ld_N3_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("ld_N3_stall", {31'b0, mem_stall}, 32'd0);
        pipe_advance = 1'b1; mem_valid = 1'b0;
        tick();
        pipe_advance = 1'b0;
        settle();
        chk("ld_after_rv", {31'b0, resp_valid}, 32'd0);

        // Halfword store with addr_ok held off 3 cycles
        mem_valid = 1'b1; mem_write = 1'b1; mem_addr = 32'h2002;
        mem_wdata = 32'hABCD_0000; mem_wstrb = 4'b1100;
        mem_size  = MEM_WIDTH2;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_wdata = 32'h1111_1111 * (i + 2);
            mem_addr  = 32'h3000 + i;
            if (i == 3) data_addr_ok = 1'b1;
            settle();
            chk("st_req", {31'b0, data_req}, 32'd1);
            chk("st_addr", data_addr, 32'h2002);
            chk("st_wdata", data_wdata, 32'hABCD_0000);
            chk("st_wstrb", {28'b0, data_wstrb}, 32'hC);
            chk("st_wr", {31'b0, data_wr}, 32'd1);
            chk("st_size", {30'b0, data_size}, 32'd1);
        end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        data_rdata = 32'h5555_5555;
        settle();
        chk("st_wait_req", {31'b0, data_req}, 32'd0);
        tick();
        data_data_ok = 1'b0;
        settle();
        chk("st_done_rv", {31'b0, resp_valid}, 32'd1);
        chk("st_done_rdata", resp_rdata, 32'h0);
        pipe_advance = 1'b1; mem_valid = 1'b0; mem_write = 1'b0;
        tick();
        pipe_advance = 1'b0;

        // Flush while request is pending, before addr_ok
        issue_load(32'h3000, MEM_WIDTH4);
        tick();
        settle();
        chk("fr_req", {31'b0, data_req}, 32'd1);
        flush = 1'b1; mem_valid = 1'b0;
        tick();
        flush = 1'b0;
        settle();
        chk("fr_req0", {31'b0, data_req}, 32'd0);
        chk("fr_stall0", {31'b0, mem_stall}, 32'd0);
        chk("fr_rv0", {31'b0, resp_valid}, 32'd0);
        tick();
        settle();
        chk("fr_rv1", {31'b0, resp_valid}, 32'd0);

        // Flush while waiting for data; late response is dropped
        issue_load(32'h4000, MEM_WIDTH4);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b1; mem_valid = 1'b0;
        settle();
        chk("fw_stall_w", {31'b0, mem_stall}, 32'd1);
        tick();
        flush = 1'b0;
        settle();
        chk("fw_c_req", {31'b0, data_req}, 32'd0);
        chk("fw_c_stall", {31'b0, mem_stall}, 32'd1);
        chk("fw_c_rv", {31'b0, resp_valid}, 32'd0);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        settle();
        chk("fw_ok_stall", {31'b0, mem_stall}, 32'd1);
        chk("fw_ok_rv", {31'b0, resp_valid}, 32'd0);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        chk("fw_end_stall", {31'b0, mem_stall}, 32'd0);
        chk("fw_end_rv", {31'b0, resp_valid}, 32'd0);
        chk("fw_end_rdata", resp_rdata, 32'h0);
        tick();
        settle();
        chk("fw_end_rv2", {31'b0, resp_valid}, 32'd0);

        // DONE held without pipe_advance; stray handshakes ignored
        issue_load(32'h5004, MEM_WIDTH4);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        data_rdata = 32'hCAFE_F00D;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            data_addr_ok = i[0]; data_data_ok = ~i[0];
            data_rdata = 32'h0BAD_0000 + i;
            settle();
            chk("hold_rv", {31'b0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, 32'hCAFE_F00D);
            chk("hold_req", {31'b0, data_req}, 32'd0);
            chk("hold_stall", {31'b0, mem_stall}, 32'd0);
            tick();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        chk("hold_rv_end", {31'b0, resp_valid}, 32'd1);
        pipe_advance = 1'b1; mem_valid = 1'b0;
        tick();
        pipe_advance = 1'b0;

        // Reset while waiting for data
        issue_load(32'h6000, MEM_WIDTH4);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        settle();
        chk("rw_stall_pre", {31'b0, mem_stall}, 32'd1);
        resetn = 1'b0;
        settle();
        chk("rw_req", {31'b0, data_req}, 32'd0);
        chk("rw_stall", {31'b0, mem_stall}, 32'd0);
        chk("rw_rv", {31'b0, resp_valid}, 32'd0);
        chk("rw_rdata", resp_rdata, 32'h0);
        chk("rw_addr", data_addr, 32'h0);
        tick();
        resetn = 1'b1; mem_valid = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        chk("rw_stray_rv", {31'b0, resp_valid}, 32'd0);
        chk("rw_stray_stall", {31'b0, mem_stall}, 32'd0);
        chk("rw_stray_rdata", resp_rdata, 32'h0);

        // Normal byte load after reset recovery
        tick();
        issue_load(32'h7001, MEM_WIDTH1);
        tick();
        data_addr_ok = 1'b1;
        settle();
        chk("nx_req", {31'b0, data_req}, 32'd1);
        chk("nx_addr", data_addr, 32'h7001);
        chk("nx_size", {30'b0, data_size}, 32'd0);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        data_rdata = 32'h0000_AB00;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        chk("nx_rv", {31'b0, resp_valid}, 32'd1);
        chk("nx_rdata", resp_rdata, 32'h0000_AB00);
        flush = 1'b1; mem_valid = 1'b0;
        tick();
        flush = 1'b0;
        settle();
        chk("nx_flush_done", {31'b0, resp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
